p_fxp_acc: RTL and testbench
============================

P_FXP_ACC -- requirements
Module: p_fxp_acc

Interface
REQ-001 Parameter I_CONF, default `DEF_DCONF_INT: dconf_t format of each input lane (sign, prec, frac).
REQ-002 Parameter O_CONF, default `DEF_DCONF_INT: dconf_t format of each accumulator/output lane.
REQ-003 Parameter LANES, default 1: number of independent accumulation lanes sharing one handshake.
REQ-004 Derived constants I_PREC = I_CONF.prec and O_PREC = O_CONF.prec SHALL be exposed as parameters.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  LANES*I_PREC  lane i occupies bits [i*I_PREC +: I_PREC].
REQ-010 in_sub  input  LANES  per lane: 1 = subtract the beat, 0 = add it.
REQ-011 in_last  input  1  beat closes the current packet.
REQ-012 out_valid  output  1  packet result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  LANES*O_PREC  per-lane saturated packet sum.
REQ-015 out_ovf  output  LANES  per lane: sticky flag, set if any beat of the packet saturated.

Function
REQ-016 A beat SHALL be accepted iff in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-017 Each accepted lane value SHALL be extended to O_CONF: sign-extended if I_CONF.sign, else zero-extended, then shifted left by O_CONF.frac - I_CONF.frac.
REQ-018 Each lane SHALL compute acc_next = sat(base ± ext(in)) at O_PREC+2 signed internal width, where base = 0 on the first beat of a packet and acc otherwise.
REQ-019 Signed O_CONF saturation limits SHALL be {0,1..1} and {1,0..0}; unsigned limits SHALL be all-ones and 0.
REQ-020 out_ovf[i] SHALL be set when lane i clamps and SHALL stay set until the packet result is consumed.
REQ-021 State machine: ACC (packet open or idle) and HOLD (result pending). Accepting in_last SHALL move ACC->HOLD.
REQ-022 out_valid SHALL assert the cycle after the in_last beat is accepted, with out_data/out_ovf equal to the final accumulator values.
REQ-023 In HOLD, out_data and out_ovf SHALL be stable while out_ready = 0.
REQ-024 When out_valid && out_ready, the block SHALL return to ACC and the next accepted beat SHALL start a new packet (base 0, ovf cleared).
REQ-025 A beat accepted in the same cycle as out_valid && out_ready SHALL be the first beat of the new packet; if that beat has in_last, out_valid SHALL stay high the next cycle with the new result.
REQ-026 A single-beat packet (first beat has in_last) SHALL yield sat(0 ± ext(in)).
REQ-027 Lanes SHALL be fully independent except for the shared handshake.
REQ-028 Elaboration SHALL fail if O_CONF.frac < I_CONF.frac or if O_CONF has fewer integer bits than I_CONF.

Reset
REQ-029 On reset: out_valid = 0, in_ready = 1, all accumulators = 0, out_ovf = 0, state = ACC, first-beat flag set.
REQ-030 Reset mid-packet or during HOLD SHALL discard all partial or pending results without emitting them.

Structure
REQ-031 dconf_t, FXP, and the saturation-limit functions for a given dconf_t SHALL reside in the shared perceptron package/header.
REQ-032 One combinational sub-module, p_fxp_sat_addsub, SHALL perform the per-lane extend / add-subtract / saturate operation and SHALL be instantiated LANES times by a generate loop.

Verification (I_CONF signed prec 8 frac 4; O_CONF signed prec 12 frac 4; LANES 2)
REQ-033 Reset released -> out_valid = 0, in_ready = 1; first packet on lane 0 of 0x10 -> out_data lane 0 = 0x010.
REQ-034 Lane 0 beats +0x10, +0x28, then sub 0x08 with last -> one cycle later out_valid = 1, lane 0 = 0x030, ovf = 0.
REQ-035 Lane 0 adds 0x7F ×20 and lane 1 subtracts 0x7F ×20 in one packet -> lane 0 = 0x7FF, lane 1 = 0x800, out_ovf = 2'b11.
REQ-036 out_ready held 0 for 5 cycles -> out_data stable and in_ready = 0; then out_ready = 1 with a 0x80+last beat in the same cycle -> next result lane 0 = 0xF80, ovf = 0.
REQ-037 Two beats accepted, reset pulsed, then 0x20+last -> result 0x020, and no output was produced for the aborted packet.

Source files
------------

// File: rtl/p_fxp_acc_pkg.sv
// Shared fixed-point helpers: format descriptor, wide carrier type and
// saturation limits for a given format.
package p_fxp_acc_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    localparam dconf_t DEF_DCONF_INT = '{sign: 1'b1, prec: 8'd16, frac: 8'd0};

    // FXP: wide signed carrier for limits and intermediate values
    typedef logic signed [63:0] fxp_t;

    function automatic fxp_t sat_max(dconf_t c);
        if (c.sign)
            return (fxp_t'(1) <<< (c.prec - 8'd1)) - fxp_t'(1);
        else
            return (fxp_t'(1) <<< c.prec) - fxp_t'(1);
    endfunction

    function automatic fxp_t sat_min(dconf_t c);
        if (c.sign)
            return -(fxp_t'(1) <<< (c.prec - 8'd1));
        else
            return fxp_t'(0);
    endfunction

    function automatic int int_bits(dconf_t c);
        return int'(c.prec) - int'(c.frac);
    endfunction

endpackage

`ifndef DEF_DCONF_INT
`define DEF_DCONF_INT p_fxp_acc_pkg::DEF_DCONF_INT
`endif

// File: rtl/p_fxp_sat_addsub.sv
// One lane: extend the input to the output format, add or subtract it from
// the base value and clamp to the output format limits.
module p_fxp_sat_addsub
    import p_fxp_acc_pkg::*;
#(
    parameter dconf_t I_CONF = `DEF_DCONF_INT,
    parameter dconf_t O_CONF = `DEF_DCONF_INT,
    parameter int     I_PREC = int'(I_CONF.prec),
    parameter int     O_PREC = int'(O_CONF.prec)
) (
    input  logic [I_PREC-1:0] in_val,
    input  logic [O_PREC-1:0] base,
    input  logic              sub,
    output logic [O_PREC-1:0] sum,
    output logic              ovf
);

    // Two guard bits hold any base +/- input without wrapping.
    localparam int W  = O_PREC + 2;
    localparam int SH = int'(O_CONF.frac) - int'(I_CONF.frac);

    localparam logic signed [W-1:0] MAX_W = W'(sat_max(O_CONF));
    localparam logic signed [W-1:0] MIN_W = W'(sat_min(O_CONF));

    logic                in_msb;
    logic                base_msb;
    logic signed [W-1:0] in_ext;
    logic signed [W-1:0] base_ext;
    logic signed [W-1:0] res;

    always_comb begin
        in_msb   = I_CONF.sign & in_val[I_PREC-1];
        base_msb = O_CONF.sign & base[O_PREC-1];
        in_ext   = $signed({{(W-I_PREC){in_msb}}, in_val}) <<< SH;
        base_ext = $signed({{(W-O_PREC){base_msb}}, base});
        res      = sub ? (base_ext - in_ext) : (base_ext + in_ext);
        sum      = res[O_PREC-1:0];
        ovf      = 1'b0;
        if (res > MAX_W) begin
            sum = MAX_W[O_PREC-1:0];
            ovf = 1'b1;
        end else if (res < MIN_W) begin
            sum = MIN_W[O_PREC-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/p_fxp_acc.sv
// Multi-lane saturating packet accumulator. Beats accumulate per lane until
// in_last; the packet sum is then held on the output until consumed.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. in_ready = !out_valid ||
// out_ready, so a new packet's first beat may enter while the previous
// result is being taken. Held outputs never change while out_ready is low.
module p_fxp_acc
    import p_fxp_acc_pkg::*;
#(
    parameter dconf_t I_CONF = `DEF_DCONF_INT,
    parameter dconf_t O_CONF = `DEF_DCONF_INT,
    parameter int     LANES  = 1,
    parameter int     I_PREC = int'(I_CONF.prec),
    parameter int     O_PREC = int'(O_CONF.prec)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*I_PREC-1:0]   in_data,
    input  logic [LANES-1:0]          in_sub,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*O_PREC-1:0]   out_data,
    output logic [LANES-1:0]          out_ovf,
    output logic [0:0]                dbg_state
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    if (int'(O_CONF.frac) < int'(I_CONF.frac) ||
        int_bits(O_CONF) < int_bits(I_CONF)) begin : g_bad_conf
        $error("p_fxp_acc: O_CONF cannot represent every I_CONF value");
    end

    logic [0:0]              state_q;
    logic                    first_q;
    logic [LANES*O_PREC-1:0] acc_q;
    logic [LANES-1:0]        ovf_q;
    logic [LANES*O_PREC-1:0] sum_w;
    logic [LANES-1:0]        lane_ovf_w;
    logic                    accept;

    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign dbg_state = state_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [O_PREC-1:0] base;
        // The first beat of a packet starts from zero, not the old result.
        assign base = first_q ? '0 : acc_q[i*O_PREC +: O_PREC];

        p_fxp_sat_addsub #(
            .I_CONF (I_CONF),
            .O_CONF (O_CONF),
            .I_PREC (I_PREC),
            .O_PREC (O_PREC)
        ) u_sat_addsub (
            .in_val (in_data[i*I_PREC +: I_PREC]),
            .base   (base),
            .sub    (in_sub[i]),
            .sum    (sum_w[i*O_PREC +: O_PREC]),
            .ovf    (lane_ovf_w[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACC;
            first_q <= 1'b1;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            if (accept) begin
                acc_q   <= sum_w;
                ovf_q   <= first_q ? lane_ovf_w : (ovf_q | lane_ovf_w);
                first_q <= in_last;
            end
            if (accept && in_last)
                state_q <= ST_HOLD;
            else if (out_valid && out_ready)
                state_q <= ST_ACC;
        end
    end

endmodule

// File: tb/tb_p_fxp_acc.sv
// Directed bench for p_fxp_acc: Q4.4 signed inputs into Q8.4 signed lanes, two lanes.
module tb_p_fxp_acc;
    import p_fxp_acc_pkg::*;

    localparam dconf_t I_CFG = '{sign: 1'b1, prec: 8'd8,  frac: 8'd4};
    localparam dconf_t O_CFG = '{sign: 1'b1, prec: 8'd12, frac: 8'd4};

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [1:0]  out_ovf;
    logic [0:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic watch = 1'b0;
    int   valid_seen = 0;

    p_fxp_acc #(
        .I_CONF (I_CFG),
        .O_CONF (O_CFG),
        .LANES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (watch && out_valid) valid_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; waits (bounded) for in_ready.
    task automatic beat(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] sub, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = {d1, d0};
        in_sub   = sub;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 2'b00;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_ovf",   32'(out_ovf),   32'h0);
        check("rst_state",     32'(dbg_state), 32'd0);

        // Single-beat packet
        beat(8'h10, 8'h00, 2'b00, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data",  32'(out_data),  32'h000010);
        check("single_state", 32'(dbg_state), 32'd1);
        consume();
        check("consume_valid", 32'(out_valid), 32'd0);

        // +0x10 +0x28 -0x08
        beat(8'h10, 8'h00, 2'b00, 1'b0);
        beat(8'h28, 8'h00, 2'b00, 1'b0);
        check("mid_pkt_valid", 32'(out_valid), 32'd0);
        beat(8'h08, 8'h00, 2'b01, 1'b1);
        check("addsub_valid", 32'(out_valid), 32'd1);
        check("addsub_data",  32'(out_data),  32'h000030);
        check("addsub_ovf",   32'(out_ovf),   32'h0);
        consume();

        // Saturation both directions
        for (int i = 0; i < 20; i++)
            beat(8'h7F, 8'h7F, 2'b10, (i == 19));
        check("sat_valid", 32'(out_valid), 32'd1);
        check("sat_data",  32'(out_data),  32'h8007FF);
        check("sat_ovf",   32'(out_ovf),   32'h3);

        // Backpressure: result held
        for (int i = 0; i < 5; i++) begin
            check("hold_data",     32'(out_data),  32'h8007FF);
            check("hold_ovf",      32'(out_ovf),   32'h3);
            check("hold_in_ready", 32'(in_ready),  32'd0);
            check("hold_valid",    32'(out_valid), 32'd1);
            @(negedge clk);
        end

        // Consume and start a single-beat packet in the same cycle
        out_ready = 1'b1;
        beat(8'h80, 8'h00, 2'b00, 1'b1);
        out_ready = 1'b0;
        check("overlap_valid", 32'(out_valid), 32'd1);
        check("overlap_data",  32'(out_data),  32'h000F80);
        check("overlap_ovf",   32'(out_ovf),   32'h0);
        consume();

        // Reset mid-packet discards partial sums
        watch = 1'b1;
        beat(8'h10, 8'h10, 2'b00, 1'b0);
        beat(8'h10, 8'h10, 2'b00, 1'b0);
        pulse_reset();
        watch = 1'b0;
        check("abort_no_output", 32'(valid_seen), 32'd0);
        check("abort_valid",     32'(out_valid),  32'd0);
        check("abort_in_ready",  32'(in_ready),   32'd1);
        check("abort_acc_zero",  32'(out_data),   32'h0);
        beat(8'h20, 8'h03, 2'b00, 1'b1);
        check("after_abort_valid", 32'(out_valid), 32'd1);
        check("after_abort_data",  32'(out_data),  32'h003020);

        // Reset during HOLD drops the pending result
        pulse_reset();
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_data",  32'(out_data),  32'h0);
        check("hold_rst_state", 32'(dbg_state), 32'd0);

        // Per-lane sub flags: lane0 0 - 0x10, lane1 0 + (-0x10)
        beat(8'h10, 8'hF0, 2'b01, 1'b1);
        check("lane_indep_data", 32'(out_data), 32'hFF0FF0);
        check("lane_indep_ovf",  32'(out_ovf),  32'h0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
